// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: receive-path constants, state codes and lcr helpers.
// Build option consumed by the receiver: UART_RX_TIMEOUT_EN.
package uart_receiver_pkg;

   localparam int UART_FIFO_COUNTER_W = 5;
   localparam int UART_FIFO_REC_WIDTH = 11;

   localparam int UART_RF_BRK = 2;
   localparam int UART_RF_PE  = 1;
   localparam int UART_RF_FE  = 0;

   // msb of the two-bit word-length field lcr[1:0]
   localparam int UART_LC_BITS = 1;
   localparam int UART_LC_SB   = 2;
   localparam int UART_LC_PE   = 3;
   localparam int UART_LC_EP   = 4;
   localparam int UART_LC_SP   = 5;

   typedef enum logic [2:0] {
      r_idle       = 3'd0,
      r_rec_start  = 3'd1,
      r_rec_bit    = 3'd2,
      r_rec_parity = 3'd3,
      r_rec_stop   = 3'd4,
      r_push       = 3'd5,
      r_wait_high  = 3'd6
   } rstate_e;

   function automatic logic [2:0] last_bit(
      input logic [7:0] lcr
   );
      return 3'd4 + {1'b0, lcr[UART_LC_BITS:0]};
   endfunction

   // four character times: 64 ticks per frame bit
   function automatic logic [9:0] toc_reload(
      input logic [7:0] lcr
   );
      logic [3:0] n;
      n = 4'd7
        + {2'b00, lcr[UART_LC_BITS:0]}
        + {3'b000, lcr[UART_LC_PE]}
        + {3'b000, lcr[UART_LC_SB]};
      return {n, 6'd0};
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: receiver <-> RX FIFO bundle.
// The receiver is the master; the FIFO side is the slave.
interface uart_receiver_if
   import uart_receiver_pkg::*;
();

   logic                           rf_push;
   logic [UART_FIFO_REC_WIDTH-1:0] rf_data_in;
   logic [UART_FIFO_COUNTER_W-1:0] rf_count;
   logic                           rf_pop;

   modport master (
      output rf_push,
      output rf_data_in,
      input  rf_count,
      input  rf_pop
   );

   modport slave (
      input  rf_push,
      input  rf_data_in,
      output rf_count,
      output rf_pop
   );

endinterface

// File: rtl/uart_sync_flops.sv
// uart_sync_flops: two-stage synchronizer for an asynchronous input.
// INIT is the value both stages hold during reset.
module uart_sync_flops #(
   parameter logic INIT = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= INIT;
         q    <= INIT;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampling serial receiver feeding the RX FIFO.
// Define UART_RX_TIMEOUT_EN to build the character-timeout counter.
module uart_receiver
   import uart_receiver_pkg::*;
(
   input  logic            clk,
   input  logic            wb_rst_ni,
   input  logic [7:0]      lcr,
   input  logic            enable,
   input  logic            srx_pad_i,
   input  logic            rx_reset,
   uart_receiver_if.master rf,
   output logic [2:0]      rstate,
   output logic            rx_timeout
);

   logic srx;

   uart_sync_flops #(
      .INIT (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (wb_rst_ni),
      .d     (srx_pad_i),
      .q     (srx)
   );

   rstate_e    state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] sr_q, sr_d;
   logic       par_q, par_d;
   logic       pe_q, pe_d;
   logic [10:0] data_q, data_d;

   logic       mid, wrap, push, brk, par_exp;
   logic [2:0] bit_pos;

   assign mid     = tick_q == 4'd7;
   assign wrap    = tick_q == 4'd15;
   assign bit_pos = last_bit(lcr) - bitcnt_q;

   // unused upper data bits stay zero, so the full-width XOR is exact
   assign par_exp = lcr[UART_LC_SP] ? ~lcr[UART_LC_EP]
                  : lcr[UART_LC_EP] ?  (^sr_q)
                  :                   ~(^sr_q);

   assign brk = (sr_q == 8'd0) && !srx
             && !(lcr[UART_LC_PE] && par_q);

   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= r_idle;
         tick_q   <= '0;
         bitcnt_q <= '0;
         sr_q     <= '0;
         par_q    <= 1'b0;
         pe_q     <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bitcnt_q <= bitcnt_d;
         sr_q     <= sr_d;
         par_q    <= par_d;
         pe_q     <= pe_d;
         data_q   <= data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bitcnt_d = bitcnt_q;
      sr_d     = sr_q;
      par_d    = par_q;
      pe_d     = pe_q;
      data_d   = data_q;
      if (rx_reset) begin
         state_d  = r_idle;
         tick_d   = '0;
         bitcnt_d = '0;
         sr_d     = '0;
         par_d    = 1'b0;
         pe_d     = 1'b0;
      end else if (enable) begin
         tick_d = tick_q + 4'd1;
         unique case (state_q)
            r_idle: begin
               if (!srx) begin
                  state_d = r_rec_start;
                  tick_d  = '0;
                  sr_d    = '0;
                  par_d   = 1'b0;
                  pe_d    = 1'b0;
               end
            end
            r_rec_start: begin
               if (mid && srx) begin
                  state_d = r_idle;
               end else if (wrap) begin
                  state_d  = r_rec_bit;
                  bitcnt_d = last_bit(lcr);
               end
            end
            r_rec_bit: begin
               if (mid) sr_d[bit_pos] = srx;
               if (wrap) begin
                  if (bitcnt_q == 3'd0)
                     state_d = lcr[UART_LC_PE] ? r_rec_parity
                                               : r_rec_stop;
                  else
                     bitcnt_d = bitcnt_q - 3'd1;
               end
            end
            r_rec_parity: begin
               if (mid) begin
                  par_d = srx;
                  pe_d  = srx != par_exp;
               end
               if (wrap) state_d = r_rec_stop;
            end
            r_rec_stop: begin
               if (mid) begin
                  state_d             = r_push;
                  data_d[10:3]        = sr_q;
                  data_d[UART_RF_BRK] = brk;
                  data_d[UART_RF_PE]  = pe_q;
                  data_d[UART_RF_FE]  = ~srx;
               end
            end
            r_push: begin
               state_d = srx ? r_idle : r_wait_high;
            end
            r_wait_high: begin
               if (srx) state_d = r_idle;
            end
            default: state_d = r_idle;
         endcase
      end
   end

   assign push          = (state_q == r_push) && enable && !rx_reset;
   assign rf.rf_push    = push;
   assign rf.rf_data_in = data_q;
   assign rstate        = state_q;

   logic unused_lcr;
   assign unused_lcr = ^lcr[7:6];

`ifdef UART_RX_TIMEOUT_EN
   logic [9:0] toc_q;
   logic       rf_empty;

   assign rf_empty = rf.rf_count == '0;

   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni)
         toc_q <= '1;
      else if (rx_reset || push || rf.rf_pop || rf_empty)
         toc_q <= toc_reload(lcr);
      else if (enable && toc_q != 10'd0)
         toc_q <= toc_q - 10'd1;
   end

   assign rx_timeout = (toc_q == 10'd0) && !rf_empty;
`else
   logic unused_rf;
   assign unused_rf  = ^{rf.rf_count, rf.rf_pop, lcr[UART_LC_SB]};
   assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table vectors, corner sequences and a random
// frame stream checked against a frame-level reference model.
module tb_uart_receiver;
   import uart_receiver_pkg::*;

   logic       clk       = 1'b0;
   logic       wb_rst_ni = 1'b0;
   logic       enable    = 1'b0;
   logic       srx_pad_i = 1'b1;
   logic       rx_reset  = 1'b0;
   logic [7:0] lcr       = 8'h03;
   logic [2:0] rstate;
   logic       rx_timeout;

   uart_receiver_if rf_if();

   uart_receiver dut (
      .clk        (clk),
      .wb_rst_ni  (wb_rst_ni),
      .lcr        (lcr),
      .enable     (enable),
      .srx_pad_i  (srx_pad_i),
      .rx_reset   (rx_reset),
      .rf         (rf_if),
      .rstate     (rstate),
      .rx_timeout (rx_timeout)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int dbl    = 0;
   logic [10:0] push_q[$];

   typedef struct {
      logic [7:0]  lcr;
      logic [7:0]  data;
      logic        flip;
      logic        stop;
      logic [10:0] exp;
   } vec_t;

   vec_t vt[9];

   // 16x strobe: one clk in four, changed just after the edge
   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clk);
         #1;
         enable = (k == 3);
         k = (k + 1) % 4;
      end
   end

   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rf_if.rf_push) push_q.push_back(rf_if.rf_data_in);
         if (rf_if.rf_push && prev) dbl++;
         prev = rf_if.rf_push;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h",
                    nm, act, exp);
   endtask

   task automatic wait_en(input int n);
      repeat (n) begin
         do @(posedge clk); while (!enable);
      end
      #2;
   endtask

   function automatic logic par_bit(input logic [7:0] l,
                                    input logic [7:0] d);
      int ones;
      ones = 0;
      for (int i = 0; i < 5 + int'(l[1:0]); i++)
         ones += int'(d[i]);
      if (l[5]) return ~l[4];
      if (l[4]) return 1'(ones % 2);
      return 1'(1 - ones % 2);
   endfunction

   function automatic logic [10:0] model(input logic [7:0] l,
                                         input logic [7:0] d,
                                         input logic flip,
                                         input logic stop);
      int         nb;
      logic [7:0] dm;
      logic       ptx, pe, brk;
      nb  = 5 + int'(l[1:0]);
      dm  = d & 8'((1 << nb) - 1);
      ptx = par_bit(l, d) ^ flip;
      pe  = l[3] & flip;
      brk = (dm == 8'd0) && !(l[3] && ptx) && !stop;
      return {dm, brk, pe, ~stop};
   endfunction

   task automatic send_frame(input logic [7:0] l, input logic [7:0] d,
                             input logic flip, input logic stop,
                             input int gap);
      int nb;
      nb  = 5 + int'(l[1:0]);
      lcr = l;
      srx_pad_i = 1'b0;
      wait_en(16);
      for (int i = 0; i < nb; i++) begin
         srx_pad_i = d[i];
         wait_en(16);
      end
      if (l[3]) begin
         srx_pad_i = par_bit(l, d) ^ flip;
         wait_en(16);
      end
      srx_pad_i = stop;
      wait_en(16);
      srx_pad_i = 1'b1;
      if (l[2]) wait_en(16);
      wait_en(gap);
   endtask

   function automatic logic [31:0] first_push();
      if (push_q.size() == 0) return 32'hDEAD_BEEF;
      return 32'(push_q[0]);
   endfunction

   initial begin
      logic [7:0] rl, rd;
      logic       rfl, rs;
      int         t;

      vt[0] = '{8'h03, 8'hA5, 1'b0, 1'b1, 11'h528};
      vt[1] = '{8'h1A, 8'h41, 1'b1, 1'b1, 11'h20A};
      vt[2] = '{8'h00, 8'h15, 1'b0, 1'b0, 11'h0A9};
      vt[3] = '{8'h0B, 8'h00, 1'b0, 1'b1, 11'h000};
      vt[4] = '{8'h29, 8'h3F, 1'b0, 1'b1, 11'h1F8};
      vt[5] = '{8'h1F, 8'hFF, 1'b0, 1'b1, 11'h7F8};
      vt[6] = '{8'h1B, 8'h00, 1'b0, 1'b0, 11'h005};
      vt[7] = '{8'h39, 8'h2A, 1'b1, 1'b1, 11'h152};
      vt[8] = '{8'h02, 8'hFF, 1'b0, 1'b1, 11'h3F8};

      rf_if.rf_count = '0;
      rf_if.rf_pop   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset rstate", 32'(rstate), 0);
      chk("reset rf_push", 32'(rf_if.rf_push), 0);
      chk("reset rf_data_in", 32'(rf_if.rf_data_in), 0);
      chk("reset rx_timeout", 32'(rx_timeout), 0);
      wb_rst_ni = 1'b1;
      wait_en(4);
      chk("idle after reset", 32'(rstate), 0);

      foreach (vt[i]) begin
         push_q.delete();
         send_frame(vt[i].lcr, vt[i].data, vt[i].flip, vt[i].stop, 4);
         chk($sformatf("vec%0d pushes", i), push_q.size(), 1);
         chk($sformatf("vec%0d entry", i), first_push(),
             32'(vt[i].exp));
         chk($sformatf("vec%0d rstate", i), 32'(rstate), 0);
      end

      // short low glitch must be rejected as a false start
      lcr = 8'h03;
      push_q.delete();
      srx_pad_i = 1'b0;
      wait_en(4);
      srx_pad_i = 1'b1;
      wait_en(1);
      chk("glitch in start", 32'(rstate), 32'(r_rec_start));
      wait_en(5);
      chk("glitch back idle", 32'(rstate), 0);
      wait_en(20);
      chk("glitch no push", push_q.size(), 0);

      // sustained break: one entry, then recovery
      push_q.delete();
      srx_pad_i = 1'b0;
      wait_en(320);
      chk("break waits high", 32'(rstate), 32'(r_wait_high));
      srx_pad_i = 1'b1;
      wait_en(20);
      chk("break pushes", push_q.size(), 1);
      chk("break entry", first_push(), 32'h005);
      send_frame(8'h03, 8'h5A, 1'b0, 1'b1, 4);
      chk("after break pushes", push_q.size(), 2);
      chk("after break entry",
          push_q.size() > 1 ? 32'(push_q[1]) : 32'hDEAD_BEEF,
          32'h2D0);

      // flush mid-character
      lcr = 8'h00;
      push_q.delete();
      srx_pad_i = 1'b0;
      wait_en(16);
      srx_pad_i = 1'b1;
      wait_en(16);
      srx_pad_i = 1'b0;
      wait_en(8);
      chk("pre-flush rstate", 32'(rstate), 32'(r_rec_bit));
      rx_reset = 1'b1;
      @(posedge clk);
      #1;
      chk("flush rstate", 32'(rstate), 0);
      rx_reset  = 1'b0;
      srx_pad_i = 1'b1;
      wait_en(60);
      chk("flush no push", push_q.size(), 0);

      for (int n = 0; n < 24; n++) begin
         rl  = {2'b00, 6'($urandom)};
         rd  = 8'($urandom);
         rfl = $urandom_range(0, 2) == 0;
         rs  = $urandom_range(0, 4) != 0;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         push_q.delete();
         send_frame(rl, rd, rfl, rs, $urandom_range(2, 12));
         chk($sformatf("rand%0d pushes", n), push_q.size(), 1);
         chk($sformatf("rand%0d entry lcr=%0h d=%0h", n, rl, rd),
             first_push(), 32'(model(rl, rd, rfl, rs)));
      end

`ifdef UART_RX_TIMEOUT_EN
      lcr = 8'h03;
      rf_if.rf_count = '0;
      srx_pad_i = 1'b0;
      wait_en(16);
      for (int i = 0; i < 8; i++) begin
         srx_pad_i = i[0];
         wait_en(16);
      end
      srx_pad_i = 1'b1;
      t = 0;
      while (!rf_if.rf_push && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("toc push seen", 32'(rf_if.rf_push), 1);
      rf_if.rf_count = 5'd1;
      @(posedge clk);
      #2;
      wait_en(639);
      chk("toc low at 639", 32'(rx_timeout), 0);
      wait_en(1);
      chk("toc high at 640", 32'(rx_timeout), 1);
      rf_if.rf_pop = 1'b1;
      @(posedge clk);
      #1;
      rf_if.rf_pop = 1'b0;
      chk("toc pop clears", 32'(rx_timeout), 0);
      wait_en(639);
      chk("toc relow at 639", 32'(rx_timeout), 0);
      wait_en(1);
      chk("toc rehigh at 640", 32'(rx_timeout), 1);
      rf_if.rf_count = '0;
      @(posedge clk);
      #1;
      chk("toc empty clears", 32'(rx_timeout), 0);
`else
      rf_if.rf_count = 5'd1;
      wait_en(700);
      chk("toc tied low", 32'(rx_timeout), 0);
      rf_if.rf_count = '0;
`endif

      chk("no back-to-back push", dbl, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive stage of the UART, the counterpart of the transmit path on the same line. It oversamples `srx_pad_i` on the shared 16x baud strobe and frames characters according to the line control register. It checks parity, framing and break conditions, then pushes one 11-bit entry per character into the receive FIFO. The block sits between the pad and the RX FIFO, in parallel with the transmitter, and is driven by the same `lcr` and `enable`.

## Interface
- Parameters: none. Widths come from the shared UART defines (`UART_FIFO_COUNTER_W`, `UART_FIFO_REC_WIDTH` = 11).
- `clk` in 1: system clock.
- `wb_rst_ni` in 1: reset, asynchronous and active-low.
- `lcr` in 8: line control.
  - [1:0] selects 5/6/7/8 data bits.
  - [2] selects 2 stop bits.
  - [3] is parity enable.
  - [4] selects even parity.
  - [5] is stick parity.
- `enable` in 1: 16x baud strobe, one `clk` wide.
- `srx_pad_i` in 1: serial input, asynchronous to `clk`.
- `rx_reset` in 1: synchronous receiver flush.
- `rf_count` in `UART_FIFO_COUNTER_W`: RX FIFO occupancy, used only for the timeout.
- `rf_pop` in 1: RX FIFO read strobe, used only for the timeout.
- `rf_push` out 1: one-`clk` push strobe to the RX FIFO.
- `rf_data_in` out 11: FIFO entry, laid out as follows.
  - [10:3] data, with unused MSBs zero.
  - [2] break.
  - [1] parity error.
  - [0] framing error.
- `rstate` out 3: current FSM state.
- `rx_timeout` out 1: character-timeout indication.

## Operation
- `srx_pad_i` passes through a 2-flop synchronizer clocked every `clk`, not gated by `enable`. The FSM uses only the synchronized value `srx`.
- The FSM advances only on `clk` cycles where `enable`=1.
- The 4-bit tick counter runs 0..15 and samples at tick 7 (mid-bit).
- **r_idle**: go to r_rec_start when `srx`=0 and clear the tick counter.
- **r_rec_start**: at tick 7, if `srx`=1 it is a false start, so return to r_idle. Otherwise go to r_rec_bit with the counter at 0 and the bit counter = data bits − 1.
- **r_rec_bit**: sample at tick 7 and shift in LSB-first. After the last bit, go to r_rec_parity if `lcr[3]`, else go to r_rec_stop.
- **r_rec_parity**: sample at tick 7. Expected parity is defined as follows.
  - With stick parity, the expected bit is `~lcr[4]`.
  - Otherwise it is the XOR of the received data bits, inverted for odd parity.
  - A mismatch sets the parity-error flag.
- **r_rec_stop**: sample the first stop bit only at tick 7.
  - `srx`=0 sets framing error.
  - Break is set when all data bits, the parity bit (if enabled) and the stop bit are 0.
  - Then go to r_push.
- **r_push**: assert `rf_push` and hold `rf_data_in` valid. If `srx`=0, go to r_wait_high; else go to r_idle.
- **r_wait_high**: stay until `srx`=1, then go to r_idle. This means a sustained break produces exactly one entry.
- State encodings are 0..6 in the order listed.
- `rx_reset`=1 takes priority over everything else.
  - It forces r_idle and clears the counters and shift register.
  - It deasserts `rf_push`.
  - An in-flight character is discarded and is never pushed.

## Timing
- Reset values:
  - `rstate` = r_idle.
  - `rf_push` = 0.
  - `rf_data_in` = 0.
  - `rx_timeout` = 0.
  - Synchronizer flops = 1.
- `rf_push` is high for exactly the one `clk` cycle in which r_push is exited. It is never high for two consecutive cycles.
- `rf_data_in` holds its value until the next push.
- Latency from the pad edge to start detection is 2 `clk` plus up to 1 `enable` period.
- Stop-bit sampling occurs 8 ticks into the stop bit, so the push lands mid-stop-bit. The remaining stop time (and a second stop bit) overlaps r_idle.
- A change of `lcr` mid-character has undefined results. Software changes `lcr` only when the line is idle.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - A 10-bit down-counter reloads to 4 character times, i.e. 64 × (1 + data bits + parity + stop bits) ticks; 8N1 gives 640.
  - It reloads on `rf_push`, on `rf_pop`, or whenever `rf_count`=0.
  - It decrements on `enable` and saturates at 0.
  - `rx_timeout` = (counter == 0) && (`rf_count` != 0).
  - `rx_reset` reloads the counter.
- Not defined: `rx_timeout` is tied to 0. The `rf_count` and `rf_pop` ports remain present and are ignored.

## Structure
- The shared UART package/defines hold:
  - the state encodings `r_idle` … `r_wait_high`;
  - `UART_FIFO_REC_WIDTH`;
  - the `rf_data_in` bit-index constants for break, parity error and framing error;
  - the `lcr` field indices (`UART_LC_PE`, `UART_LC_EP`, `UART_LC_SP`, `UART_LC_SB`, `UART_LC_BITS`).
- One sub-module, `uart_sync_flops`, implements the 2-flop synchronizer with a reset value parameter. Everything else stays flat in `uart_receiver`.

## Test plan
- 8N1, receive 0xA5 → one `rf_push`, `rf_data_in` = {0xA5, 3'b000}, `rstate` returns to 0.
- 7E1, send 0x41 with the parity bit forced to 1 → `rf_data_in[1]`=1, data = 0x41.
- Glitch low for 4 ticks on an idle line → no push, `rstate` back to r_idle by tick 7.
- 8N1, line held low for 2 character times → exactly one push with data 0x00 and flags 3'b101. No further push until the line goes high and a new start bit arrives.
- 5N1, send 0x15 with the stop bit low → data 0x15, flags 3'b001. Assert `rx_reset` mid-way through a second character → no push, `rstate` = 0 the next cycle.
- With `UART_RX_TIMEOUT_EN`, 8N1: one character received, `rf_count`=1 held, no pops → `rx_timeout` rises exactly 640 `enable` ticks after the push. A single `rf_pop` drops it and restarts the count.
